// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_ctrl_pkg
// Description : Shared types and encodings for the multicycle RV32I control
//               unit: FSM state enum, opcode constants, datapath mux select
//               encodings, ALU operation codes and an opcode legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    // Controller states. Encodings 13..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_LUI      = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    // ALU A operand select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate type
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALUOp: class of operation requested by the FSM
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_JAL, OP_BEQ, OP_LUI: is_legal_op = 1'b1;
            default:                is_legal_op = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational ALU control decoder. Maps the FSM's ALUOp class
//               plus funct3 / op[5] / instr[30] to the ALU operation code.
// Ports       : alu_op_i      [1:0] operation class from the FSM
//               funct3_i      [2:0] instr[14:12]
//               op5_i               instr[5] (1 = R-type, 0 = I-type)
//               funct7b5_i          instr[30]
//               alu_control_o [2:0] ALU operation
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type uses instr[30] to select sub; an addi whose
                    // immediate happens to set bit 30 must still add.
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore-style control FSM for the multicycle RV32I datapath.
//               Sequences fetch/decode/execute/memory/writeback (3..5 cycles
//               per instruction) and drives every datapath select/enable.
// Ports       : clk, rst_n            clock, async active-low reset
//               op, funct3, funct7b5  instruction fields
//               zero                  ALU zero flag (branch resolution)
//               PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  enables/selects
//               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl mux selects
//               instr_done            final state of each instruction
//               illegal_op            DECODE-cycle pulse for unsupported op
// Parameters  : ILLEGAL_HALT  1 = park in HALT on illegal op, 0 = refetch
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state_q, state_d;

    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       done;
    logic       illegal;
    logic [1:0] alu_op;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = S_FETCH;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        alu_op    = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                pc_update = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target / jal target as OldPC + imm
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        illegal = 1'b1;
                        state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                done      = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // PC <= ALUOut (target from DECODE); ALU computes OldPC+4
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                alu_op    = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                branch    = 1'b1;
                done      = 1'b1;
                state_d   = S_FETCH;
            end
            S_LUI: begin
                ResultSrc = RES_IMMEXT;
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Enables are qualified by rst_n combinationally so that asserting
    // reset kills them immediately, and FETCH (the reset state) does not
    // present IRWrite/PCWrite while reset is held.
    // ------------------------------------------------------------------
    assign PCWrite    = rst_n & (pc_update | (branch & zero));
    assign IRWrite    = rst_n & ir_write;
    assign RegWrite   = rst_n & reg_write;
    assign MemWrite   = rst_n & mem_write;
    assign instr_done = rst_n & done;
    assign illegal_op = rst_n & illegal;

    // ------------------------------------------------------------------
    // Immediate type, decoded straight from the opcode
    // ------------------------------------------------------------------
    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_STORE: ImmSrc = IMM_S;
            OP_BEQ:   ImmSrc = IMM_B;
            OP_JAL:   ImmSrc = IMM_J;
            OP_LUI:   ImmSrc = IMM_U;
            default:  ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (ALUControl)
    );

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control unit for the multicycle RV32I datapath.
- A Moore state machine sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Generates every datapath select and enable, including the 2-bit ResultSrc consumed by the result mux (00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt).
- Contains a combinational ALU decoder and an immediate-type decoder.

Parameters:
- ILLEGAL_HALT, 0: when 1, an unsupported opcode parks the FSM in HALT until reset. When 0, the FSM returns to FETCH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  instr[6:0], from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register and OldPC enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result mux select.
- ALUSrcA  out  2  ALU A operand: 00 PC, 01 OldPC, 10 rd1.
- ALUSrcB  out  2  ALU B operand: 00 rd2, 01 ImmExt, 10 constant 4.
- ImmSrc  out  3  immediate type: I 000, S 001, B 010, J 011, U 100.
- ALUControl  out  3  ALU operation: add 000, sub 001, and 010, or 011, slt 101.
- instr_done  out  1  high in the final state of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- While rst_n is low:
  - State is FETCH.
  - PCWrite, IRWrite, RegWrite, MemWrite, instr_done and illegal_op are forced to 0.
  - Other outputs hold their FETCH values.
  - The first clock edge after release executes FETCH.
- Output style:
  - Outputs are decoded from the state only (Moore).
  - Exceptions: PCWrite = PCUpdate | (Branch & zero); ImmSrc is decoded from op; ALUControl is decoded from ALUOp, funct3, op[5] and funct7b5.
  - Any field not listed for a state is 0.
- States, with non-zero outputs and next state:
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCUpdate 1 -> DECODE.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00. Next state by op:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 1101111 -> JAL.
    - 1100011 -> BEQ.
    - 0110111 -> LUI.
    - Any other op -> FETCH (or HALT when ILLEGAL_HALT=1), with illegal_op pulsed.
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00 -> MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: ResultSrc 00, AdrSrc 1 -> MEMWB.
  - MEMWB: ResultSrc 01, RegWrite 1, instr_done 1 -> FETCH.
  - MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1, instr_done 1 -> FETCH.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10 -> ALUWB.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10 -> ALUWB.
  - ALUWB: ResultSrc 00, RegWrite 1, instr_done 1 -> FETCH.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1 -> ALUWB.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1, instr_done 1 -> FETCH.
  - LUI: ResultSrc 11, RegWrite 1, instr_done 1 -> FETCH.
  - HALT: all enables 0; self-loop until rst_n is asserted.
- Latency in cycles: lw 5, sw 4, R/I-type 4, jal 4, beq 3, lui 3.
- ImmSrc decode from op:
  - 0100011 -> 001.
  - 1100011 -> 010.
  - 1101111 -> 011.
  - 0110111 -> 100.
  - All other op values -> 000.
- ALUControl decode:
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000 -> sub if (op[5] & funct7b5), else add. An I-type addi with instr[30]=1 is therefore add.
    - 010 -> slt.
    - 110 -> or.
    - 111 -> and.
    - Any other funct3 -> add.
- Reset mid-instruction aborts immediately; no write enable may glitch high during reset.
- Encoded state register has no illegal values: an unreachable encoding goes to FETCH.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum state_t.
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ, OP_LUI.
  - ResultSrc, ALUSrcA, ALUSrcB, ImmSrc and ALUControl encodings.
  - The result mux imports the ResultSrc encodings from the same package.
- One sub-module: alu_decoder (ALUOp, funct3, op5, funct7b5 -> ALUControl). The FSM and ImmSrc decode stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release; feed lw (op 0000011).
  - During reset: all enables 0.
  - After release, in order: FETCH IRWrite=1, PCWrite=1; DECODE; MEMADR; MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1, instr_done=1.
- sub x3,x1,x2 (op 0110011, funct3 000, funct7b5=1).
  - EXECUTER: ALUControl=001.
  - ALUWB: RegWrite=1, ResultSrc=00.
  - addi with instr[30]=1 yields ALUControl=000.
- beq with zero=1: PCWrite=1 in BEQ, 3-cycle instruction. Same with zero=0: PCWrite=0.
- lui (op 0110111): ImmSrc=100; LUI state ResultSrc=11, RegWrite=1; next FETCH on cycle 4.
- Illegal op 1111111:
  - ILLEGAL_HALT=0: illegal_op pulses 1 cycle, then FETCH.
  - ILLEGAL_HALT=1: HALT, all enables 0 for 10 cycles; rst_n low recovers to FETCH.
- sw, with rst_n dropped asynchronously mid-MEMWRITE: MemWrite falls to 0 without waiting for a clock edge; the restart fetch begins at FETCH.
